// File: rtl/call_pkg.sv
// Shared types for the runtime call-stack controller: default sizing,
// function-id and frame types, the stack entry layout and the FSM states.
package call_pkg;

  localparam int unsigned NUM_FUNC = 10;
  localparam int unsigned ARITY    = 2;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned FRAME_W  = 7;
  localparam int unsigned FID_W    = $clog2(NUM_FUNC);

  typedef logic [FID_W-1:0] func_id_t;

  // Word 0 of a frame is the resume pc of the suspended caller.
  typedef logic [FRAME_W-1:0][DATA_W-1:0] frame_t;

  typedef struct packed {
    func_id_t id;
    frame_t   frame;
  } stack_entry_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_POP  = 2'd2,
    S_ERR  = 2'd3
  } state_t;

endpackage

// File: rtl/frame_stack.sv
// LIFO of saved caller frames: synchronous write at sp, registered read of
// the top-of-stack entry (sp-1). The pointer is exported only when
// CALL_STACK_STATS_EN is defined, for depth statistics.
module frame_stack
  import call_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned SP_W = AW + 1
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_push,
  input  stack_entry_t    i_wdata,
  input  logic            i_rd_en,
  input  logic            i_pop,
  output stack_entry_t    o_rdata,
  output logic            o_full,
  output logic            o_empty
`ifdef CALL_STACK_STATS_EN
  ,
  output logic [SP_W-1:0] o_sp
`endif
);

  stack_entry_t    r_mem [DEPTH];
  stack_entry_t    r_rdata;
  logic [SP_W-1:0] r_sp;
  logic [AW-1:0]   w_wr_addr;
  logic [AW-1:0]   w_rd_addr;

  assign w_wr_addr = r_sp[AW-1:0];
  assign w_rd_addr = AW'(r_sp - SP_W'(1));

  // Storage write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[w_wr_addr] <= i_wdata;
  end

  // Registered read of the current top entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)        r_rdata <= '0;
    else if (i_rd_en) r_rdata <= r_mem[w_rd_addr];
  end

  // Stack pointer: number of valid entries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       r_sp <= '0;
    else if (i_push) r_sp <= r_sp + SP_W'(1);
    else if (i_pop)  r_sp <= r_sp - SP_W'(1);
  end

  assign o_rdata = r_rdata;
  assign o_full  = (r_sp == SP_W'(DEPTH));
  assign o_empty = (r_sp == '0);
`ifdef CALL_STACK_STATS_EN
  assign o_sp    = r_sp;
`endif

endmodule

// File: rtl/call_stack_ctrl.sv
// Runtime call-stack controller: launches the entry function, pushes the
// caller frame on nontail calls, pops and resumes the caller on returns, and
// reports the entry function's return value.
// Optional macro CALL_STACK_STATS_EN adds max_depth / call_count outputs.
module call_stack_ctrl
  import call_pkg::*;
#(
  parameter int unsigned NUM_FUNC = call_pkg::NUM_FUNC,
  parameter int unsigned ARITY    = call_pkg::ARITY,
  parameter int unsigned DATA_W   = call_pkg::DATA_W,
  parameter int unsigned FRAME_W  = call_pkg::FRAME_W,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned MAIN_ID  = 1
) (
  input  logic                                         clk,
  input  logic                                         rstn,
  input  logic                                         go,
  input  logic [ARITY-1:0][DATA_W-1:0]                 main_args,
  input  logic [NUM_FUNC-1:0]                          end_of_func,
  input  logic [NUM_FUNC-1:0]                          nontail_call,
  input  logic [NUM_FUNC-1:0][ARITY-1:0][DATA_W-1:0]   call_args_i,
  input  logic [NUM_FUNC-1:0][DATA_W-1:0]              ret_i,
  input  logic [NUM_FUNC-1:0][DATA_W-1:0]              func_i,
  input  logic [NUM_FUNC-1:0][FRAME_W-1:0][DATA_W-1:0] save_i,
  output logic [NUM_FUNC-1:0]                          start,
  output logic [ARITY-1:0][DATA_W-1:0]                 args,
  output logic [DATA_W-1:0]                            get,
  output logic [FRAME_W-1:0][DATA_W-1:0]               restore,
  output logic                                         busy,
  output logic                                         done,
  output logic [DATA_W-1:0]                            result,
  output logic                                         err
`ifdef CALL_STACK_STATS_EN
  ,
  output logic [$clog2(DEPTH):0]                       max_depth,
  output logic [DATA_W-1:0]                            call_count
`endif
);

  state_t                          r_state;
  state_t                          w_state_nxt;
  func_id_t                        r_cur;
  logic [NUM_FUNC-1:0]             r_start;
  logic [ARITY-1:0][DATA_W-1:0]    r_args;
  logic [DATA_W-1:0]               r_get;
  logic [FRAME_W-1:0][DATA_W-1:0]  r_restore;
  logic                            r_busy;
  logic                            r_done;
  logic [DATA_W-1:0]               r_result;
  logic                            r_err;
  logic [DATA_W-1:0]               r_ret_hold;

  logic          w_launch, w_push, w_rd, w_pop, w_final, w_fault;
  logic          w_cur_end, w_cur_call, w_bad_callee;
  logic          w_full, w_empty;
  logic [DATA_W-1:0] w_callee_raw;
  func_id_t      w_callee;
  stack_entry_t  w_push_entry;
  stack_entry_t  w_rdata;
`ifdef CALL_STACK_STATS_EN
  logic [$clog2(DEPTH):0] w_sp;
  logic [$clog2(DEPTH):0] r_max_depth;
  logic [DATA_W-1:0]      r_call_count;
`endif

  // Only the running function's handshake bits matter.
  assign w_cur_end    = end_of_func[r_cur];
  assign w_cur_call   = nontail_call[r_cur];
  assign w_callee_raw = func_i[r_cur];
  assign w_callee     = func_id_t'(w_callee_raw);
  assign w_bad_callee = (w_callee_raw == '0) || (w_callee_raw >= DATA_W'(NUM_FUNC));

  assign w_push_entry.id    = r_cur;
  assign w_push_entry.frame = save_i[r_cur];

  frame_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_rd_en (w_rd),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty)
`ifdef CALL_STACK_STATS_EN
    ,
    .o_sp    (w_sp)
`endif
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and event decode. The stack read is issued in the return
  // cycle itself so the popped entry is ready when POP registers outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_push      = 1'b0;
    w_rd        = 1'b0;
    w_pop       = 1'b0;
    w_final     = 1'b0;
    w_fault     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (go) begin
          w_launch    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_cur_end && w_cur_call) begin
          w_fault     = 1'b1;
          w_state_nxt = S_ERR;
        end else if (w_cur_call) begin
          if (w_full || w_bad_callee) begin
            w_fault     = 1'b1;
            w_state_nxt = S_ERR;
          end else begin
            w_push = 1'b1;
          end
        end else if (w_cur_end) begin
          if (w_empty) begin
            w_final     = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_rd        = 1'b1;
            w_state_nxt = S_POP;
          end
        end
      end
      S_POP: begin
        w_pop       = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_ERR:   w_state_nxt = S_ERR;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and current-function tracking.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cur      <= '0;
      r_start    <= '0;
      r_args     <= '0;
      r_get      <= '0;
      r_restore  <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_err      <= 1'b0;
      r_ret_hold <= '0;
    end else begin
      r_start <= '0;
      r_done  <= 1'b0;
      r_busy  <= (w_state_nxt != S_IDLE);
      if (w_launch) begin
        r_args           <= main_args;
        r_restore        <= '0;
        r_cur            <= func_id_t'(MAIN_ID);
        r_start[MAIN_ID] <= 1'b1;
      end
      if (w_push) begin
        r_args            <= call_args_i[r_cur];
        r_restore         <= '0;
        r_cur             <= w_callee;
        r_start[w_callee] <= 1'b1;
      end
      if (w_rd) r_ret_hold <= ret_i[r_cur];
      if (w_pop) begin
        r_get              <= r_ret_hold;
        r_restore          <= w_rdata.frame;
        r_cur              <= w_rdata.id;
        r_start[w_rdata.id] <= 1'b1;
      end
      if (w_final) begin
        r_result <= ret_i[r_cur];
        r_done   <= 1'b1;
      end
      if (w_fault) r_err <= 1'b1;
    end
  end

`ifdef CALL_STACK_STATS_EN
  // Peak stack depth and call counter, cleared on each accepted launch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_max_depth  <= '0;
      r_call_count <= '0;
    end else if (w_launch) begin
      r_max_depth  <= '0;
      r_call_count <= '0;
    end else begin
      if (w_push)              r_call_count <= r_call_count + DATA_W'(1);
      if (w_sp > r_max_depth)  r_max_depth  <= w_sp;
    end
  end

  assign max_depth  = r_max_depth;
  assign call_count = r_call_count;
`endif

  assign start   = r_start;
  assign args    = r_args;
  assign get     = r_get;
  assign restore = r_restore;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;
  assign err     = r_err;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// Bench for call_stack_ctrl: a recursive factorial function model at id 1
// answers start pulses; two controller instances (DEPTH 64 and DEPTH 4).
module tb_call_stack_ctrl;

  localparam int unsigned NF = 10;
  localparam int unsigned AR = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned FW = 7;

  logic clk = 1'b0;
  logic rstn;
  logic go, go4, sel;
  logic [AR-1:0][DW-1:0] main_args;
  logic [NF-1:0] m_eof, m_ntc, h_eof;
  logic [NF-1:0] eof_a, ntc_a, eof_b, ntc_b;
  logic [NF-1:0][AR-1:0][DW-1:0] m_cargs;
  logic [NF-1:0][DW-1:0] m_ret, m_func;
  logic [NF-1:0][FW-1:0][DW-1:0] m_save;

  logic [NF-1:0] start_a, start_b;
  logic [AR-1:0][DW-1:0] args_a, args_b;
  logic [DW-1:0] get_a, get_b, result_a, result_b;
  logic [FW-1:0][DW-1:0] restore_a, restore_b;
  logic busy_a, busy_b, done_a, done_b, err_a, err_b;
`ifdef CALL_STACK_STATS_EN
  logic [6:0] md_a;
  logic [2:0] md_b;
  logic [DW-1:0] cc_a, cc_b;
`endif

  assign eof_a = sel ? '0 : (m_eof | h_eof);
  assign ntc_a = sel ? '0 : m_ntc;
  assign eof_b = sel ? (m_eof | h_eof) : '0;
  assign ntc_b = sel ? m_ntc : '0;

  always #5 clk = ~clk;

  call_stack_ctrl #(.DEPTH(64)) u_dut (
    .clk(clk), .rstn(rstn), .go(go), .main_args(main_args),
    .end_of_func(eof_a), .nontail_call(ntc_a), .call_args_i(m_cargs),
    .ret_i(m_ret), .func_i(m_func), .save_i(m_save),
    .start(start_a), .args(args_a), .get(get_a), .restore(restore_a),
    .busy(busy_a), .done(done_a), .result(result_a), .err(err_a)
`ifdef CALL_STACK_STATS_EN
    , .max_depth(md_a), .call_count(cc_a)
`endif
  );

  call_stack_ctrl #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rstn(rstn), .go(go4), .main_args(main_args),
    .end_of_func(eof_b), .nontail_call(ntc_b), .call_args_i(m_cargs),
    .ret_i(m_ret), .func_i(m_func), .save_i(m_save),
    .start(start_b), .args(args_b), .get(get_b), .restore(restore_b),
    .busy(busy_b), .done(done_b), .result(result_b), .err(err_b)
`ifdef CALL_STACK_STATS_EN
    , .max_depth(md_b), .call_count(cc_b)
`endif
  );

  typedef struct {
    int unsigned n;
    bit          dut4;
    bit          inject;
    int unsigned exp_result;
    int          exp_starts;
    bit          exp_err;
  } vec_t;

  int    n_checks = 0;
  int    n_err    = 0;
  int    cyc      = 0;
  int    exp_start, exp_done, exp_err, m_depth, dlim, n_starts;
  bit    done_seen, err_seen;
  string exp_kind;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // A return from the model: final if the model is at depth 0.
  task automatic note_return();
    if (m_depth == 0) exp_done = cyc + 1;
    else begin
      m_depth--;
      exp_start = cyc + 2;
      exp_kind  = "ret";
    end
  endtask

  // One cycle: advance to the falling edge, observe the selected DUT and
  // let the factorial model answer any start pulse in this same cycle.
  task automatic tick();
    logic [NF-1:0]         s_start;
    logic [AR-1:0][DW-1:0] s_args;
    logic [FW-1:0][DW-1:0] s_restore;
    logic [DW-1:0]         s_get, nval;
    logic                  s_done, s_err;
    @(negedge clk);
    cyc++;
    m_eof = '0; m_ntc = '0; h_eof = '0; go = 1'b0; go4 = 1'b0;
    if (!rstn) begin
      m_depth = 0; exp_start = -1; exp_done = -1; exp_err = -1;
      return;
    end
    s_start   = sel ? start_b   : start_a;
    s_args    = sel ? args_b    : args_a;
    s_restore = sel ? restore_b : restore_a;
    s_get     = sel ? get_b     : get_a;
    s_done    = sel ? done_b    : done_a;
    s_err     = sel ? err_b     : err_a;
    if (s_done) begin
      chk("done_lat", cyc, exp_done);
      exp_done  = -1;
      done_seen = 1'b1;
    end
    if (s_err && !err_seen) begin
      err_seen = 1'b1;
      chk("err_lat", cyc, exp_err);
    end
    if (s_start != '0) begin
      n_starts++;
      chk("start_id1_onehot", s_start, 64'd2);
      chk({exp_kind, "_lat"}, cyc, exp_start);
      exp_start = -1;
      if (s_restore[0] == '0) begin
        nval = s_args[0];
        if (nval <= 1) begin
          m_ret[1] = 1;
          m_eof[1] = 1'b1;
          note_return();
        end else begin
          m_func[1]     = 1;
          m_cargs[1][0] = nval - 1;
          m_save[1][0]  = 1;
          m_save[1][1]  = nval;
          m_ntc[1]      = 1'b1;
          if (m_depth == dlim) exp_err = cyc + 1;
          else begin
            m_depth++;
            exp_start = cyc + 1;
            exp_kind  = "call";
          end
        end
      end else begin
        m_ret[1] = s_restore[1] * s_get;
        m_eof[1] = 1'b1;
        note_return();
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    sel = v.dut4;
    dlim = v.dut4 ? 4 : 64;
    n_starts = 0; m_depth = 0; done_seen = 0; err_seen = 0;
    exp_done = -1; exp_err = -1;
    tick();
    main_args    = '0;
    main_args[0] = v.n;
    if (v.dut4) go4 = 1'b1; else go = 1'b1;
    exp_start = cyc + 1;
    exp_kind  = "go";
    k = 0;
    while (!done_seen && !err_seen && k < 500) begin
      tick();
      k++;
      if (v.inject && k == 3) begin
        go       = 1'b1;
        h_eof[2] = 1'b1;
      end
    end
    chk($sformatf("finish_n%0d", v.n), done_seen || err_seen, 1);
    if (v.exp_err) begin
      repeat (10) tick();
      chk("ovf_err", sel ? err_b : err_a, 1);
      chk("ovf_busy", sel ? busy_b : busy_a, 1);
      chk("ovf_starts", n_starts, v.exp_starts);
      chk("ovf_no_done", done_seen, 0);
      rstn = 1'b0;
      #1;
      chk("ovf_rst_err", err_b, 0);
      chk("ovf_rst_busy", busy_b, 0);
      tick(); tick();
      rstn = 1'b1;
    end else begin
      chk($sformatf("result_n%0d", v.n), sel ? result_b : result_a, v.exp_result);
      chk($sformatf("starts_n%0d", v.n), n_starts, v.exp_starts);
      chk($sformatf("err_n%0d", v.n), sel ? err_b : err_a, 0);
      chk($sformatf("busy_end_n%0d", v.n), sel ? busy_b : busy_a, 0);
`ifdef CALL_STACK_STATS_EN
      chk($sformatf("max_depth_n%0d", v.n), sel ? md_b : md_a, v.n - 1);
      chk($sformatf("call_count_n%0d", v.n), sel ? cc_b : cc_a, v.n - 1);
`endif
    end
  endtask

  initial begin
    vec_t vecs [7];
    vec_t v3;
    int k;
    vecs[0] = '{1, 1'b0, 1'b0,   1, 1, 1'b0};
    vecs[1] = '{5, 1'b0, 1'b0, 120, 9, 1'b0};
    vecs[2] = '{2, 1'b0, 1'b0,   2, 3, 1'b0};
    vecs[3] = '{4, 1'b1, 1'b0,  24, 7, 1'b0};
    vecs[4] = '{5, 1'b1, 1'b0, 120, 9, 1'b0};
    vecs[5] = '{6, 1'b1, 1'b0,   0, 5, 1'b1};
    vecs[6] = '{5, 1'b0, 1'b1, 120, 9, 1'b0};
    v3      = '{3, 1'b0, 1'b0,   6, 5, 1'b0};

    rstn = 1'b0; go = 1'b0; go4 = 1'b0; sel = 1'b0;
    main_args = '0; m_eof = '0; m_ntc = '0; h_eof = '0;
    m_cargs = '0; m_ret = '0; m_func = '0; m_save = '0;
    exp_kind = "go";
    tick(); tick();
    chk("rst_start", start_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_err", err_a, 0);
    chk("rst_result", result_a, 0);
    chk("rst_args", args_a, 0);
    chk("rst_get", get_a, 0);
    chk("rst_restore", |restore_a, 0);
    rstn = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Asynchronous reset in the middle of fact(5) with three frames pushed.
    sel = 1'b0; dlim = 64; n_starts = 0; m_depth = 0;
    done_seen = 0; err_seen = 0; exp_done = -1; exp_err = -1;
    tick();
    main_args    = '0;
    main_args[0] = 5;
    go        = 1'b1;
    exp_start = cyc + 1;
    exp_kind  = "go";
    k = 0;
    while (m_depth != 3 && k < 200) begin
      tick();
      k++;
    end
    chk("midrst_reach_depth3", m_depth, 3);
    @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("midrst_start", start_a, 0);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_args", args_a, 0);
    chk("midrst_restore", |restore_a, 0);
    chk("midrst_get", get_a, 0);
    chk("midrst_done_err", {done_a, err_a}, 0);
    tick(); tick();
    rstn = 1'b1;
    run_vec(v3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
